// File: rtl/projectile_pkg.sv
// Shared projectile geometry: pixel coordinate type and fixed-point sizing helpers,
// used by the projectile pool and the draw/collision blocks.
package projectile_pkg;

    localparam int COORD_W = 11;

    typedef logic [COORD_W-1:0] coord_t;

    // Signed fixed-point width: sign bit + integer pixels + fraction.
    function automatic int fp_width(input int frac_bits);
        return frac_bits + COORD_W + 1;
    endfunction

    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/projectile_pool_if.sv
// Control/status bundle between ship logic and the projectile pool.
interface projectile_pool_if
    import projectile_pkg::*;
#(
    parameter int NUM_SHOTS = 3
);
    logic                           startOfFrame;
    logic                           enable;
    logic                           fire;
    coord_t                         ship_x;
    coord_t                         ship_y;
    logic [NUM_SHOTS-1:0]           collision;
    logic [NUM_SHOTS-1:0]           active;
    logic [COORD_W*NUM_SHOTS-1:0]   proj_x;
    logic [COORD_W*NUM_SHOTS-1:0]   proj_y;
    logic                           fire_ack;

    modport master (
        output startOfFrame, enable, fire, ship_x, ship_y, collision,
        input  active, proj_x, proj_y, fire_ack
    );

    modport slave (
        input  startOfFrame, enable, fire, ship_x, ship_y, collision,
        output active, proj_x, proj_y, fire_ack
    );
endinterface

// File: rtl/projectile_slot.sv
// One projectile slot: spawn load, sticky hit latch, per-frame upward move with
// acceleration and retire on hit or leaving the top of the screen.
module projectile_slot
    import projectile_pkg::*;
#(
    parameter int FRAC_BITS = 6,
    parameter int SPEED     = 10,
    parameter int ACC       = 3,
    parameter int MAX_SPEED = 500,
    parameter int Y_TOP     = 2
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   spawn,
    input  coord_t                 spawn_x,
    input  logic signed [COORD_W:0] spawn_y,
    input  logic                   sof_en,
    input  logic                   collision,
    output logic                   active,
    output coord_t                 pos_x,
    output coord_t                 pos_y
);
    localparam int FP_W = fp_width(FRAC_BITS);
    typedef logic signed [FP_W-1:0] fixed_t;

    localparam fixed_t SPEED_F = fixed_t'(SPEED);
    localparam fixed_t ACC_F   = fixed_t'(ACC);
    localparam fixed_t MAX_F   = fixed_t'(MAX_SPEED);
    localparam fixed_t Y_LIMIT = fixed_t'(Y_TOP * (1 << FRAC_BITS));

    logic   active_q, active_d;
    logic   hit_q, hit_d;
    coord_t x_q, x_d;
    fixed_t y_q, y_d;
    fixed_t speed_q, speed_d;

    logic   hit_now;
    fixed_t y_step;
    fixed_t speed_inc;

    always_comb begin
        // A hit arriving on the SOF cycle itself still retires the slot now.
        hit_now   = hit_q | (collision & active_q);
        y_step    = y_q - speed_q;
        speed_inc = speed_q + ACC_F;
        active_d  = active_q;
        hit_d     = hit_now;
        x_d       = x_q;
        y_d       = y_q;
        speed_d   = speed_q;
        if (spawn) begin
            active_d = 1'b1;
            hit_d    = 1'b0;
            x_d      = spawn_x;
            y_d      = spawn_y[COORD_W] ? '0 : (fixed_t'(spawn_y) <<< FRAC_BITS);
            speed_d  = SPEED_F;
        end else if (sof_en && active_q) begin
            if (hit_now) begin
                active_d = 1'b0;
                hit_d    = 1'b0;
            end else if (y_step < Y_LIMIT) begin
                active_d = 1'b0;
            end else begin
                y_d     = y_step;
                speed_d = (speed_inc > MAX_F) ? MAX_F : speed_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            active_q <= 1'b0;
            hit_q    <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            speed_q  <= '0;
        end else begin
            active_q <= active_d;
            hit_q    <= hit_d;
            x_q      <= x_d;
            y_q      <= y_d;
            speed_q  <= speed_d;
        end
    end

    assign active = active_q;
    assign pos_x  = x_q;
    assign pos_y  = y_q[FRAC_BITS +: COORD_W];

endmodule

// File: rtl/projectile_pool.sv
// Multi-shot player projectile pool: fire edge detect, cooldown, lowest-free-slot
// allocation, and one projectile_slot per shot.
module projectile_pool
    import projectile_pkg::*;
#(
    parameter int NUM_SHOTS = 3,
    parameter int FRAC_BITS = 6,
    parameter int SPEED     = 10,
    parameter int ACC       = 3,
    parameter int MAX_SPEED = 500,
    parameter int COOLDOWN  = 8,
    parameter int X_OFFSET  = 0,
    parameter int Y_OFFSET  = 33,
    parameter int Y_TOP     = 2
) (
    input  logic                     clk,
    input  logic                     resetN,
    projectile_pool_if.slave         bus
);
    localparam int CD_W    = cnt_width(COOLDOWN);
    localparam int SPAWN_W = COORD_W + 1;

    logic                   fire_q, fire_d;
    logic                   fire_ack_q, fire_ack_d;
    logic [CD_W-1:0]        cooldown_q, cooldown_d;

    logic [NUM_SHOTS-1:0]   active_w;
    logic [NUM_SHOTS-1:0]   grant;
    coord_t                 slot_x [NUM_SHOTS];
    coord_t                 slot_y [NUM_SHOTS];
    logic                   fire_request;
    logic                   accept;
    logic                   sof_en;
    logic                   found;
    coord_t                 spawn_x;
    logic signed [COORD_W:0] spawn_y;

    assign spawn_x = coord_t'(32'(bus.ship_x) + X_OFFSET);
    assign spawn_y = $signed({1'b0, bus.ship_y}) - $signed(SPAWN_W'(Y_OFFSET));

    always_comb begin
        fire_request = bus.fire & ~fire_q & bus.enable;
        sof_en       = bus.startOfFrame & bus.enable;
        // Allocation sees the free mask before this cycle's SOF retirements.
        accept       = fire_request & (cooldown_q == '0) & |(~active_w);
        grant        = '0;
        found        = 1'b0;
        for (int i = 0; i < NUM_SHOTS; i++) begin
            if (!active_w[i] && !found) begin
                found    = 1'b1;
                grant[i] = accept;
            end
        end
        fire_d     = bus.fire;
        fire_ack_d = accept;
        cooldown_d = cooldown_q;
        if (accept)
            cooldown_d = CD_W'(COOLDOWN);
        else if (sof_en && cooldown_q != '0)
            cooldown_d = cooldown_q - 1'b1;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            fire_q     <= 1'b0;
            fire_ack_q <= 1'b0;
            cooldown_q <= '0;
        end else begin
            fire_q     <= fire_d;
            fire_ack_q <= fire_ack_d;
            cooldown_q <= cooldown_d;
        end
    end

    for (genvar gi = 0; gi < NUM_SHOTS; gi++) begin : g_slot
        projectile_slot #(
            .FRAC_BITS (FRAC_BITS),
            .SPEED     (SPEED),
            .ACC       (ACC),
            .MAX_SPEED (MAX_SPEED),
            .Y_TOP     (Y_TOP)
        ) u_slot (
            .clk       (clk),
            .resetN    (resetN),
            .spawn     (grant[gi]),
            .spawn_x   (spawn_x),
            .spawn_y   (spawn_y),
            .sof_en    (sof_en),
            .collision (bus.collision[gi]),
            .active    (active_w[gi]),
            .pos_x     (slot_x[gi]),
            .pos_y     (slot_y[gi])
        );
    end

    always_comb begin
        bus.proj_x = '0;
        bus.proj_y = '0;
        for (int i = 0; i < NUM_SHOTS; i++) begin
            bus.proj_x[i*COORD_W +: COORD_W] = slot_x[i];
            bus.proj_y[i*COORD_W +: COORD_W] = slot_y[i];
        end
    end

    assign bus.active   = active_w;
    assign bus.fire_ack = fire_ack_q;

endmodule

// File: tb/tb_projectile_pool.sv
// Self-checking bench for projectile_pool: behavioural model feeds a scoreboard of
// expected outputs per cycle, plus directed checks of the headline scenarios.
module tb_projectile_pool;
    import projectile_pkg::*;

    localparam int N     = 3;
    localparam int F     = 6;
    localparam int SPEED = 10;
    localparam int ACC   = 3;
    localparam int MAXS  = 500;
    localparam int CD    = 8;
    localparam int XO    = 0;
    localparam int YO    = 33;
    localparam int YT    = 2;

    logic clk = 1'b0;
    logic resetN;
    always #5 clk = ~clk;

    projectile_pool_if #(.NUM_SHOTS(N)) bus();

    projectile_pool #(
        .NUM_SHOTS(N), .FRAC_BITS(F), .SPEED(SPEED), .ACC(ACC), .MAX_SPEED(MAXS),
        .COOLDOWN(CD), .X_OFFSET(XO), .Y_OFFSET(YO), .Y_TOP(YT)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    typedef struct packed {
        logic                  ack;
        logic [N-1:0]          act;
        logic [N-1:0][10:0]    x;
        logic [N-1:0][10:0]    y;
    } snap_t;

    snap_t sb_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    step_no  = 0;

    bit    m_act [N];
    bit    m_hit [N];
    int    m_x   [N];
    int    m_y   [N];
    int    m_spd [N];
    int    m_cd;
    bit    m_fire_q;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int slot_x(input int i);
        logic [N*11-1:0] v;
        v = bus.proj_x;
        return int'(v[i*11 +: 11]);
    endfunction

    function automatic int slot_y(input int i);
        logic [N*11-1:0] v;
        v = bus.proj_y;
        return int'(v[i*11 +: 11]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_act[i] = 0; m_hit[i] = 0; m_x[i] = 0; m_y[i] = 0; m_spd[i] = 0;
        end
        m_cd     = 0;
        m_fire_q = 0;
        sb_q.delete();
    endtask

    // Drive one cycle of inputs, predict the registered result, compare after the edge.
    task automatic step(input bit f, input bit s, input bit e, input logic [N-1:0] c);
        snap_t exp_s, got_s;
        bit    req, acc, sof_en, hit;
        int    idx, yn, ys;
        bus.fire = f; bus.startOfFrame = s; bus.enable = e; bus.collision = c;
        req = f && !m_fire_q && e;
        idx = -1;
        for (int i = 0; i < N; i++) if (!m_act[i] && idx < 0) idx = i;
        acc    = req && (m_cd == 0) && (idx >= 0);
        sof_en = s && e;
        for (int i = 0; i < N; i++) begin
            hit = m_hit[i] | (c[i] & m_act[i]);
            m_hit[i] = hit;
            if (m_act[i] && sof_en) begin
                if (hit) begin
                    m_act[i] = 0; m_hit[i] = 0;
                end else begin
                    yn = m_y[i] - m_spd[i];
                    if (yn < YT * (1 << F)) m_act[i] = 0;
                    else begin
                        m_y[i]   = yn;
                        m_spd[i] = (m_spd[i] + ACC > MAXS) ? MAXS : m_spd[i] + ACC;
                    end
                end
            end
        end
        if (acc) begin
            ys = int'(bus.ship_y) - YO;
            m_act[idx] = 1; m_hit[idx] = 0; m_spd[idx] = SPEED;
            m_x[idx]   = (int'(bus.ship_x) + XO) & 2047;
            m_y[idx]   = (ys < 0) ? 0 : ys * (1 << F);
        end
        if (acc) m_cd = CD;
        else if (sof_en && m_cd > 0) m_cd--;
        m_fire_q = f;
        exp_s.ack = acc;
        for (int i = 0; i < N; i++) begin
            exp_s.act[i] = m_act[i];
            exp_s.x[i]   = 11'(m_x[i]);
            exp_s.y[i]   = 11'(m_y[i] >> F);
        end
        sb_q.push_back(exp_s);
        @(posedge clk); #1;
        step_no++;
        got_s = exp_s;
        if (sb_q.size() == 0) check($sformatf("sb_empty@%0d", step_no), 0, 1);
        else begin
            got_s = sb_q.pop_front();
            check($sformatf("ack@%0d", step_no), int'(bus.fire_ack), int'(got_s.ack));
            check($sformatf("active@%0d", step_no), int'(bus.active), int'(got_s.act));
            for (int i = 0; i < N; i++) begin
                check($sformatf("x%0d@%0d", i, step_no), slot_x(i), int'(got_s.x[i]));
                check($sformatf("y%0d@%0d", i, step_no), slot_y(i), int'(got_s.y[i]));
            end
        end
        bus.startOfFrame = 0;
        bus.collision    = '0;
    endtask

    task automatic do_reset();
        bus.fire = 0; bus.startOfFrame = 0; bus.enable = 0; bus.collision = '0;
        resetN = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_active", int'(bus.active), 0);
        check("rst_ack", int'(bus.fire_ack), 0);
        check("rst_px", int'(bus.proj_x), 0);
        check("rst_py", int'(bus.proj_y), 0);
        resetN = 1;
        model_reset();
    endtask

    initial begin
        bus.ship_x = '0; bus.ship_y = '0;
        do_reset();

        // First shot from (300,400) lands at (300,367)
        bus.ship_x = 11'd300; bus.ship_y = 11'd400;
        step(1, 0, 1, '0);
        check("first_ack", int'(bus.fire_ack), 1);
        check("first_x", slot_x(0), 300);
        check("first_y", slot_y(0), 367);
        // 23488 -> 23478 -> 23465 -> 23449 fixed, all 366 px
        for (int k = 0; k < 3; k++) begin
            step(1, 1, 1, '0);
            check("early_y", slot_y(0), 366);
            check("early_x", slot_x(0), 300);
        end
        repeat (17) step(1, 1, 1, '0);

        step(0, 0, 1, '0);
        step(1, 0, 1, '0);
        check("second_ack", int'(bus.fire_ack), 1);
        step(0, 0, 1, '0);
        repeat (3) step(0, 1, 1, '0);
        step(1, 0, 1, '0);
        check("cooldown_block", int'(bus.fire_ack), 0);
        step(0, 0, 1, '0);
        repeat (5) step(0, 1, 1, '0);
        step(1, 0, 1, '0);
        check("third_ack", int'(bus.fire_ack), 1);
        step(0, 0, 1, '0);
        repeat (8) step(0, 1, 1, '0);
        step(1, 0, 1, '0);
        check("full_noack", int'(bus.fire_ack), 0);
        check("full_active", int'(bus.active), 7);

        // Disabled: collision latches, SOF and fire ignored
        step(0, 1, 0, 3'b010);
        step(1, 0, 0, '0);
        step(0, 0, 0, '0);
        step(0, 1, 1, '0);
        check("hit_retire", int'(bus.active), 5);
        step(0, 1, 1, 3'b001);
        check("hit_same_sof", int'(bus.active), 4);
        step(1, 0, 1, '0);
        step(0, 0, 1, '0);

        // Asynchronous reset mid-flight
        #2 resetN = 0;
        #1;
        check("async_active", int'(bus.active), 0);
        check("async_ack", int'(bus.fire_ack), 0);
        @(posedge clk); #1;
        resetN = 1;
        model_reset();

        // Spawn above the screen clamps to y=0 and retires on the next SOF
        bus.ship_x = 11'd50; bus.ship_y = 11'd10;
        step(1, 0, 1, '0);
        check("clamp_y", slot_y(0), 0);
        check("clamp_x", slot_x(0), 50);
        step(0, 1, 1, '0);
        check("clamp_retire", int'(bus.active), 0);

        // Top-of-screen retire coinciding with a rejected fire, then slot reuse
        do_reset();
        bus.ship_x = 11'd120; bus.ship_y = 11'd100;
        step(1, 0, 1, '0);
        step(0, 0, 1, '0);
        repeat (8) step(0, 1, 1, '0);
        step(1, 0, 1, '0);
        step(0, 0, 1, '0);
        repeat (8) step(0, 1, 1, '0);
        step(1, 0, 1, '0);
        step(0, 0, 1, '0);
        repeat (33) step(0, 1, 1, '0);
        check("pre_top_active", int'(bus.active), 7);
        step(1, 1, 1, '0);
        check("top_drop_ack", int'(bus.fire_ack), 0);
        check("top_retire", int'(bus.active), 6);
        check("top_frozen_y", slot_y(0), 4);
        step(0, 0, 1, '0);
        step(1, 0, 1, '0);
        check("reuse_ack", int'(bus.fire_ack), 1);
        check("reuse_active", int'(bus.active), 7);
        check("reuse_y", slot_y(0), 67);
        step(0, 0, 1, '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
